// File: rtl/mux_4to1.sv
// 4-to-1 lane selector: combinational y, enable-gated registered y_q.
// Define MUX_4TO1_SEL_MON_EN to build the select-change monitor (sel_chg/sel_cnt).
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4*WIDTH-1:0] d,
  input  logic [1:0]         s,
  input  logic               en,
  output logic [WIDTH-1:0]   y,
  output logic [WIDTH-1:0]   y_q,
  output logic               sel_chg,
  output logic [7:0]         sel_cnt
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;

  // Every select value has an arm, so no latch and no priority chain.
  always_comb begin
    w_y = d[0 +: WIDTH];
    case (s)
      2'd0: w_y = d[0*WIDTH +: WIDTH];
      2'd1: w_y = d[1*WIDTH +: WIDTH];
      2'd2: w_y = d[2*WIDTH +: WIDTH];
      2'd3: w_y = d[3*WIDTH +: WIDTH];
      default: w_y = d[0 +: WIDTH];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q <= '0;
    end else if (en) begin
      r_y_q <= w_y;
    end
  end

  assign y   = w_y;
  assign y_q = r_y_q;

`ifdef MUX_4TO1_SEL_MON_EN
  logic [1:0] r_s_q;
  logic       r_sel_chg;
  logic [7:0] r_sel_cnt;
  logic       w_sel_diff;

  // s_q resets to 0, so the first post-reset edge with s != 0 counts.
  assign w_sel_diff = (s != r_s_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q     <= 2'd0;
      r_sel_chg <= 1'b0;
      r_sel_cnt <= 8'd0;
    end else begin
      r_s_q     <= s;
      r_sel_chg <= w_sel_diff;
      if (w_sel_diff) begin
        r_sel_cnt <= r_sel_cnt + 8'd1;
      end
    end
  end

  assign sel_chg = r_sel_chg;
  assign sel_cnt = r_sel_cnt;
`else
  assign sel_chg = 1'b0;
  assign sel_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_mux_4to1.sv
// Directed bench for mux_4to1: WIDTH=1 and WIDTH=8 instances share clock, reset and select.
// Monitor expectations follow whether MUX_4TO1_SEL_MON_EN is defined for the build.
module tb_mux_4to1;

`ifdef MUX_4TO1_SEL_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] s;
  logic       en;

  logic [3:0]  d1;
  logic        y1, yq1, chg1;
  logic [7:0]  cnt1;

  logic [31:0] d8;
  logic [7:0]  y8, yq8, cnt8;
  logic        chg8;

  int n_checks = 0;
  int n_fail   = 0;

  mux_4to1 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .s(s), .en(en),
    .y(y1), .y_q(yq1), .sel_chg(chg1), .sel_cnt(cnt1)
  );

  mux_4to1 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .s(s), .en(en),
    .y(y8), .y_q(yq8), .sel_chg(chg8), .sel_cnt(cnt8)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [1:0] seq_s   [5] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd0};
  logic       seq_chg [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] lane8   [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic       y1_exp  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    rst_n = 1'b0;
    s     = 2'd0;
    en    = 1'b0;
    d1    = 4'b0000;
    d8    = 32'h0;
    #1;
    check("reset_yq1", {7'd0, yq1}, 8'h00);
    check("reset_yq8", yq8, 8'h00);
    check("reset_chg", {7'd0, chg8}, 8'h00);
    check("reset_cnt", cnt8, 8'h00);

    // Combinational select, held in reset so no register moves.
    d1 = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      check($sformatf("comb_w1_s%0d", i), {7'd0, y1}, {7'd0, y1_exp[i]});
    end

    d8 = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      #1;
      check($sformatf("lane_w8_s%0d", i), y8, lane8[i]);
    end
    s  = 2'd1;
    d8 = {8'h12, 8'h34, 8'hBB, 8'h56};
    #1;
    check("lane_isolate_a", y8, 8'hBB);
    d8 = {8'hFF, 8'h00, 8'hBB, 8'hFF};
    #1;
    check("lane_isolate_b", y8, 8'hBB);

    // Registered path.
    @(negedge clk);
    rst_n = 1'b1;
    s  = 2'd2;
    d1 = 4'b0100;
    en = 1'b1;
    @(posedge clk); #1;
    check("yq_load", {7'd0, yq1}, 8'h01);
    @(negedge clk);
    en = 1'b0;
    d1 = 4'b0000;
    @(posedge clk); #1;
    check("yq_hold", {7'd0, yq1}, 8'h01);
    check("y_follows_d", {7'd0, y1}, 8'h00);

    // Monitor sequence from a fresh reset.
    @(negedge clk);
    rst_n = 1'b0;
    s = 2'd0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s = seq_s[i];
      @(posedge clk); #1;
      check($sformatf("mon_chg_%0d", i), {7'd0, chg8}, {7'd0, MON & seq_chg[i]});
    end
    check("mon_cnt", cnt8, MON ? 8'd3 : 8'd0);

    // Async reset between edges with y_q=1 and sel_cnt=3.
    @(negedge clk);
    d1 = 4'b0001;
    en = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_yq", {7'd0, yq1}, 8'h01);
    check("pre_rst_cnt", cnt1, MON ? 8'd3 : 8'd0);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_yq", {7'd0, yq1}, 8'h00);
    check("arst_cnt", cnt1, 8'h00);
    check("arst_chg", {7'd0, chg1}, 8'h00);
    check("arst_y", {7'd0, y1}, 8'h01);
    d1 = 4'b0010;
    s  = 2'd1;
    #1;
    check("arst_y_follow", {7'd0, y1}, 8'h01);
    s  = 2'd0;
    en = 1'b0;
    #1;
    rst_n = 1'b1;

    // 256 consecutive changes wrap the counter.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      s = (i % 2 == 0) ? 2'd1 : 2'd0;
      @(posedge clk); #1;
      if (i == 254) check("wrap_cnt_255", cnt8, MON ? 8'd255 : 8'd0);
    end
    check("wrap_cnt_0", cnt8, 8'd0);
    check("wrap_chg", {7'd0, chg8}, {7'd0, MON});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
